// File: rtl/enums_pkg.sv
// Shared enumerations for the ALU datapath
// and the request scheduler.
package enums_pkg;

  typedef enum logic [3:0] {
    NOP    = 4'd0,
    ADD    = 4'd1,
    SUB    = 4'd2,
    AND    = 4'd3,
    OR     = 4'd4,
    XOR    = 4'd5,
    SHIFTL = 4'd6,
    SHIFTR = 4'd7
  } OP_CODE;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } SCHED_STATE;

endpackage

// File: rtl/alu.sv
// Combinational 8-bit ALU; carry is always
// the unsigned carry of a+b.
module alu
  import enums_pkg::*;
(
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  OP_CODE     op,
  output logic [7:0] res,
  output logic       carry
);

  logic [8:0] sum;

  assign sum   = {1'b0, a} + {1'b0, b};
  assign carry = sum[8];

  // Operation select; unknown encodings yield 0
  always_comb begin
    res = '0;
    case (op)
      ADD:     res = sum[7:0];
      SUB:     res = a - b;
      AND:     res = a & b;
      OR:      res = a | b;
      XOR:     res = a ^ b;
      SHIFTL:  res = a << 1;
      SHIFTR:  res = a >> 1;
      default: res = '0;
    endcase
  end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: first requester after
// ptr wins, wrapping modulo NUM_REQ.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    gnt_idx,
  output logic               any_gnt
);

  // Scan farthest-first so the nearest hit wins
  always_comb begin : arb
    int idx;
    gnt     = '0;
    gnt_idx = '0;
    any_gnt = 1'b0;
    idx     = 0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (req[idx]) begin
        any_gnt = 1'b1;
        gnt_idx = ID_W'(idx);
      end
    end
    if (any_gnt) gnt[gnt_idx] = 1'b1;
  end

endmodule

// File: rtl/alu_rr_sched.sv
// Shares one ALU between NUM_REQ requesters
// with round-robin grant and tagged responses.
module alu_rr_sched
  import enums_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [NUM_REQ*8-1:0] req_a,
  input  logic [NUM_REQ*8-1:0] req_b,
  input  OP_CODE               req_op [NUM_REQ],
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [ID_W-1:0]      rsp_id,
  output logic [7:0]           rsp_res,
  output logic                 rsp_carry,
  output logic                 busy
);

  SCHED_STATE state, state_nxt;

  logic [ID_W-1:0]    rr_ptr;
  logic [ID_W-1:0]    gnt_idx;
  logic [ID_W-1:0]    id_q;
  logic [NUM_REQ-1:0] gnt;
  logic               any_gnt;
  logic               acc;
  logic [7:0]         a_q, b_q;
  OP_CODE             op_q;
  logic [7:0]         alu_res;
  logic               alu_carry;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .req     (req_valid),
    .ptr     (rr_ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any_gnt (any_gnt)
  );

  alu u_alu (
    .a     (a_q),
    .b     (b_q),
    .op    (op_q),
    .res   (alu_res),
    .carry (alu_carry)
  );

  assign acc       = (state == IDLE) && any_gnt;
  assign req_ready = (state == IDLE && rst_n)
                   ? gnt : '0;
  assign rsp_valid = (state == RESP);
  assign rsp_id    = id_q;
  assign busy      = (state != IDLE);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state: grant, one exec cycle, hold response
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (any_gnt)   state_nxt = EXEC;
      EXEC:                   state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  // Capture granted operands, then register the result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr    <= ID_W'(NUM_REQ - 1);
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= NOP;
      id_q      <= '0;
      rsp_res   <= '0;
      rsp_carry <= 1'b0;
    end else begin
      if (acc) begin
        a_q    <= req_a[int'(gnt_idx)*8 +: 8];
        b_q    <= req_b[int'(gnt_idx)*8 +: 8];
        op_q   <= req_op[gnt_idx];
        id_q   <= gnt_idx;
        rr_ptr <= gnt_idx;
      end
      if (state == EXEC) begin
        rsp_res   <= alu_res;
        rsp_carry <= alu_carry;
      end
    end
  end

endmodule

// File: tb/tb_alu_rr_sched.sv
// Scoreboard bench for alu_rr_sched: model
// predicts grants and results, monitor compares.
module tb_alu_rr_sched;
  import enums_pkg::*;

  localparam int N  = 4;
  localparam int IW = 2;

  logic           clk = 1'b0;
  logic           rst_n = 1'b1;
  logic [N-1:0]   req_valid = '0;
  logic [N-1:0]   req_ready;
  logic [N*8-1:0] req_a = '0;
  logic [N*8-1:0] req_b = '0;
  OP_CODE         req_op [N];
  logic           rsp_valid;
  logic           rsp_ready = 1'b0;
  logic [IW-1:0]  rsp_id;
  logic [7:0]     rsp_res;
  logic           rsp_carry;
  logic           busy;

  alu_rr_sched #(.NUM_REQ(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_op    (req_op),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_res   (rsp_res),
    .rsp_carry (rsp_carry),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         id;
    logic [7:0] res;
    logic       c;
    int         cyc;
  } exp_t;

  exp_t q[$];
  int   rsp_ids[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   acc_cnt = 0;
  int   rsp_cnt = 0;
  int   m_ptr = N - 1;
  int   last_gnt = -1;
  int   last_id = -1;
  int   id_cnt [N];
  bit   m_busy = 1'b0;
  bit   hold = 1'b0;
  logic [7:0]    last_res, h_res;
  logic          last_c, h_c;
  logic [IW-1:0] h_id;
  logic [7:0]    res_by_id [N];
  logic          c_by_id [N];

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  function automatic int mgrant(input logic [N-1:0] v,
                                input int p);
    for (int k = 1; k <= N; k++)
      if (v[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  function automatic logic [8:0] malu(input logic [7:0] a,
                                      input logic [7:0] b,
                                      input OP_CODE op);
    logic [8:0] s;
    logic [7:0] r;
    s = {1'b0, a} + {1'b0, b};
    case (op)
      ADD:     r = s[7:0];
      SUB:     r = a - b;
      AND:     r = a & b;
      OR:      r = a | b;
      XOR:     r = a ^ b;
      SHIFTL:  r = {a[6:0], 1'b0};
      SHIFTR:  r = {1'b0, a[7:1]};
      default: r = 8'h00;
    endcase
    return {s[8], r};
  endfunction

  // Monitor: predict grant, push on accept, pop on response
  always @(negedge clk) begin
    int g;
    bit acc;
    logic [N-1:0] er;
    logic [8:0] m;
    exp_t e;
    cyc++;
    if (!rst_n) begin
      q.delete();
      m_busy = 1'b0;
      m_ptr  = N - 1;
      hold   = 1'b0;
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_req_ready", req_ready, 0);
      check("rst_busy", busy, 0);
    end else begin
      g   = mgrant(req_valid, m_ptr);
      acc = !m_busy && g >= 0;
      er  = '0;
      if (acc) er[g] = 1'b1;
      check("req_ready", req_ready, er);
      check("busy", busy, m_busy);
      if (q.size() == 0) begin
        check("rsp_spurious", rsp_valid, 0);
      end else if (rsp_valid) begin
        if (hold) begin
          check("hold_id", rsp_id, h_id);
          check("hold_res", rsp_res, h_res);
          check("hold_carry", rsp_carry, h_c);
        end else begin
          check("latency", cyc - q[0].cyc, 2);
        end
        if (rsp_ready) begin
          e = q.pop_front();
          check("rsp_id", rsp_id, e.id);
          check("rsp_res", rsp_res, e.res);
          check("rsp_carry", rsp_carry, e.c);
          last_id  = int'(rsp_id);
          last_res = rsp_res;
          last_c   = rsp_carry;
          res_by_id[rsp_id] = rsp_res;
          c_by_id[rsp_id]   = rsp_carry;
          id_cnt[rsp_id]++;
          rsp_ids.push_back(int'(rsp_id));
          rsp_cnt++;
          m_busy = 1'b0;
          hold   = 1'b0;
        end else begin
          hold = 1'b1;
          h_id = rsp_id;
          h_res = rsp_res;
          h_c  = rsp_carry;
        end
      end
      if (acc) begin
        m = malu(req_a[g*8 +: 8], req_b[g*8 +: 8], req_op[g]);
        e.id  = g;
        e.res = m[7:0];
        e.c   = m[8];
        e.cyc = cyc;
        q.push_back(e);
        m_ptr    = g;
        m_busy   = 1'b1;
        last_gnt = g;
        acc_cnt++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic set_req(input int i, input logic v,
                         input logic [7:0] a,
                         input logic [7:0] b,
                         input OP_CODE op);
    req_valid[i]     = v;
    req_a[i*8 +: 8]  = a;
    req_b[i*8 +: 8]  = b;
    req_op[i]        = op;
  endtask

  task automatic wait_acc(input int t);
    for (int i = 0; i < 60 && acc_cnt < t; i++) tick();
    check("acc_wait", acc_cnt, t);
  endtask

  task automatic wait_rsp(input int t);
    for (int i = 0; i < 200 && rsp_cnt < t; i++) tick();
    check("rsp_wait", rsp_cnt, t);
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && (q.size() != 0 || m_busy); i++)
      tick();
    check("drain", q.size(), 0);
  endtask

  task automatic single(input int i,
                        input logic [7:0] a,
                        input logic [7:0] b,
                        input OP_CODE op);
    int ta, tr;
    ta = acc_cnt + 1;
    tr = rsp_cnt + 1;
    set_req(i, 1'b1, a, b, op);
    wait_acc(ta);
    req_valid[i] = 1'b0;
    wait_rsp(tr);
  endtask

  initial begin
    int base, c1;
    for (int i = 0; i < N; i++) begin
      req_op[i] = NOP;
      id_cnt[i] = 0;
    end
    #1 rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check("init_rsp_valid", rsp_valid, 0);
    check("init_rsp_id", rsp_id, 0);
    check("init_rsp_res", rsp_res, 0);
    check("init_rsp_carry", rsp_carry, 0);
    check("init_busy", busy, 0);
    check("init_req_ready", req_ready, 0);

    // single ADD with carry out
    rsp_ready = 1'b1;
    single(0, 8'h0F, 8'hF1, ADD);
    check("add_id", last_id, 0);
    check("add_res", last_res, 8'h00);
    check("add_carry", last_c, 1);

    // round robin over all four requesters
    do_reset();
    rsp_ids.delete();
    set_req(0, 1'b1, 8'hF0, 8'h0F, OR);
    set_req(1, 1'b1, 8'h3C, 8'h0F, AND);
    set_req(2, 1'b1, 8'hAA, 8'hFF, XOR);
    set_req(3, 1'b1, 8'h05, 8'h07, SUB);
    base = rsp_cnt;
    wait_rsp(base + 8);
    req_valid = '0;
    drain();
    for (int k = 0; k < 8; k++)
      check("rr_order", rsp_ids[k], k % N);
    check("or_res", res_by_id[0], 8'hFF);
    check("and_res", res_by_id[1], 8'h0C);
    check("xor_res", res_by_id[2], 8'h55);
    check("sub_res", res_by_id[3], 8'hFE);
    check("sub_carry", c_by_id[3], 0);

    // backpressure during RESP
    rsp_ready = 1'b0;
    set_req(1, 1'b1, 8'h11, 8'h22, ADD);
    wait_acc(acc_cnt + 1);
    req_valid[1] = 1'b0;
    set_req(2, 1'b1, 8'h44, 8'h0F, AND);
    for (int i = 0; i < 7; i++) tick();
    check("stall_valid", rsp_valid, 1);
    check("stall_busy", busy, 1);
    check("stall_ready", req_ready, 0);
    rsp_ready = 1'b1;
    wait_acc(acc_cnt + 1);
    check("post_stall_gnt", last_gnt, 2);
    req_valid[2] = 1'b0;
    drain();

    // shifts, NOP and an undefined encoding
    single(0, 8'h81, 8'h00, SHIFTL);
    check("shl_res", last_res, 8'h02);
    single(0, 8'h81, 8'h00, SHIFTR);
    check("shr_res", last_res, 8'h40);
    single(0, 8'h12, 8'h34, NOP);
    check("nop_res", last_res, 8'h00);
    single(0, 8'hFF, 8'h01, OP_CODE'(4'hC));
    check("ill_res", last_res, 8'h00);
    check("ill_carry", last_c, 1);

    // reset while in EXEC drops the transaction
    set_req(0, 1'b1, 8'h01, 8'h02, ADD);
    wait_acc(acc_cnt + 1);
    rst_n = 1'b0;
    req_valid = '0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    single(2, 8'h10, 8'h20, ADD);
    check("rst_gnt2", last_gnt, 2);
    check("rst_id2", last_id, 2);
    do_reset();
    for (int i = 0; i < N; i++) req_valid[i] = 1'b1;
    wait_acc(acc_cnt + 1);
    check("rst_first_gnt", last_gnt, 0);
    req_valid = '0;
    drain();

    // withdrawn valid is skipped
    rsp_ready = 1'b0;
    set_req(0, 1'b1, 8'h01, 8'h01, ADD);
    wait_acc(acc_cnt + 1);
    req_valid[0] = 1'b0;
    c1 = id_cnt[1];
    set_req(1, 1'b1, 8'h02, 8'h02, ADD);
    set_req(3, 1'b1, 8'h03, 8'h03, ADD);
    tick();
    tick();
    tick();
    req_valid[1] = 1'b0;
    tick();
    rsp_ready = 1'b1;
    wait_acc(acc_cnt + 1);
    check("wd_gnt", last_gnt, 3);
    req_valid[3] = 1'b0;
    drain();
    check("wd_no_id1", id_cnt[1], c1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
